// File: rtl/vad_pkg.sv
// Shared encodings for the VAD decision path: raw class codes and sequencer states.
package vad_pkg;

    localparam logic [1:0] CLS_NONE = 2'b00;
    localparam logic [1:0] CLS_1    = 2'b10;
    localparam logic [1:0] CLS_2    = 2'b01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMP    = 2'd1,
        SMOOTH = 2'd2,
        OUT    = 2'd3
    } state_e;

endpackage

// File: rtl/vad_hangover.sv
// Speech hangover smoother: holds the speech flag for HANG_LEN frames after the last raw speech frame.
module vad_hangover #(
    parameter int unsigned HANG_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic upd,
    input  logic raw_speech,
    output logic vad
);

    localparam logic [7:0] HANG_INIT = 8'(HANG_LEN);

    logic [7:0] hang_q, hang_d;
    logic       vad_q, vad_d;

    always_comb begin
        hang_d = hang_q;
        vad_d  = vad_q;
        if (upd) begin
            if (raw_speech) begin
                hang_d = HANG_INIT;
                vad_d  = 1'b1;
            end else if (hang_q != '0) begin
                hang_d = hang_q - 8'd1;
                vad_d  = 1'b1;
            end else begin
                vad_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hang_q <= '0;
            vad_q  <= 1'b0;
        end else begin
            hang_q <= hang_d;
            vad_q  <= vad_d;
        end
    end

    assign vad = vad_q;

endmodule

// File: rtl/vad_decision_ctrl.sv
// Frame sequencer: score capture, signed compare, optional hangover smoothing, valid/ready decision output.
// Hangover smoothing is enabled by defining VAD_HANGOVER_EN.
module vad_decision_ctrl
    import vad_pkg::*;
#(
    parameter int unsigned SCORE_W  = 16,
    parameter int unsigned HANG_LEN = 8,
    parameter int unsigned FCNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      score_valid,
    output logic                      score_ready,
    input  logic signed [SCORE_W-1:0] score0,
    input  logic signed [SCORE_W-1:0] score1,
    output logic                      dec_valid,
    input  logic                      dec_ready,
    output logic [1:0]                dec_class,
    output logic                      dec_vad,
    output logic [FCNT_W-1:0]         frame_cnt,
    output logic                      busy
);

    if (HANG_LEN < 1 || HANG_LEN > 255) begin : g_hang_len_check
        $error("HANG_LEN must be in 1..255");
    end

    state_e                    state_q, state_d;
    logic signed [SCORE_W-1:0] s0_q, s0_d, s1_q, s1_d;
    logic [1:0]                cls_q, cls_d;
    logic [FCNT_W-1:0]         fcnt_q, fcnt_d;
    logic                      speech_cmp;

    assign speech_cmp = (s1_q >= s0_q);

`ifdef VAD_HANGOVER_EN
    logic hang_vad;

    vad_hangover #(.HANG_LEN(HANG_LEN)) u_hangover (
        .clk        (clk),
        .rst        (rst),
        .clr        (clear),
        .upd        (state_q == SMOOTH),
        .raw_speech (cls_q == CLS_1),
        .vad        (hang_vad)
    );

    assign dec_vad = hang_vad;
`else
    logic vad_q, vad_d;

    assign dec_vad = vad_q;
`endif

    always_comb begin
        state_d     = state_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        cls_d       = cls_q;
        fcnt_d      = fcnt_q;
        score_ready = 1'b0;
        dec_valid   = 1'b0;
`ifndef VAD_HANGOVER_EN
        vad_d       = vad_q;
`endif
        case (state_q)
            IDLE: begin
                score_ready = !rst;
                if (score_valid) begin
                    s0_d    = score0;
                    s1_d    = score1;
                    state_d = CMP;
                end
            end
            CMP: begin
                cls_d = speech_cmp ? CLS_1 : CLS_2;
`ifdef VAD_HANGOVER_EN
                state_d = SMOOTH;
`else
                vad_d   = speech_cmp;
                state_d = OUT;
`endif
            end
`ifdef VAD_HANGOVER_EN
            SMOOTH: state_d = OUT;
`endif
            OUT: begin
                dec_valid = 1'b1;
                if (dec_ready) begin
                    fcnt_d  = fcnt_q + FCNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q <= IDLE;
            s0_q    <= '0;
            s1_q    <= '0;
            cls_q   <= CLS_NONE;
            fcnt_q  <= '0;
`ifndef VAD_HANGOVER_EN
            vad_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            cls_q   <= cls_d;
            fcnt_q  <= fcnt_d;
`ifndef VAD_HANGOVER_EN
            vad_q   <= vad_d;
`endif
        end
    end

    assign dec_class = cls_q;
    assign frame_cnt = fcnt_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vad_decision_ctrl.sv
// Self-checking bench for vad_decision_ctrl against a frame-level reference model (hangover via VAD_HANGOVER_EN).
module tb_vad_decision_ctrl;

    localparam int HL = 2;
`ifdef VAD_HANGOVER_EN
    localparam int LAT     = 3;
    localparam bit HANG_ON = 1'b1;
`else
    localparam int LAT     = 2;
    localparam bit HANG_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst, clear, score_valid, dec_ready;
    logic signed [15:0] score0, score1;
    logic               score_ready, dec_valid, dec_vad, busy;
    logic [1:0]         dec_class;
    logic [15:0]        frame_cnt;
    logic               w_score_ready, w_dec_valid, w_dec_vad, w_busy;
    logic [1:0]         w_dec_class;
    logic [1:0]         w_frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int m_hang   = 0;
    int m_fcnt   = 0;

    always #5 clk = ~clk;

    vad_decision_ctrl #(.SCORE_W(16), .HANG_LEN(HL), .FCNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .clear(clear),
        .score_valid(score_valid), .score_ready(score_ready),
        .score0(score0), .score1(score1),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_class(dec_class), .dec_vad(dec_vad),
        .frame_cnt(frame_cnt), .busy(busy)
    );

    // Narrow-counter instance sharing the same stimulus, used for wrap checking.
    vad_decision_ctrl #(.SCORE_W(16), .HANG_LEN(HL), .FCNT_W(2)) u_wrap (
        .clk(clk), .rst(rst), .clear(clear),
        .score_valid(score_valid), .score_ready(w_score_ready),
        .score0(score0), .score1(score1),
        .dec_valid(w_dec_valid), .dec_ready(dec_ready),
        .dec_class(w_dec_class), .dec_vad(w_dec_vad),
        .frame_cnt(w_frame_cnt), .busy(w_busy)
    );

    task automatic model_frame(input logic signed [15:0] s1, input logic signed [15:0] s0,
                               output logic [1:0] cls, output logic vad);
        bit speech;
        speech = (s1 >= s0);
        cls = speech ? 2'b10 : 2'b01;
        if (HANG_ON) begin
            if (speech) begin
                m_hang = HL;
                vad = 1'b1;
            end else if (m_hang > 0) begin
                m_hang = m_hang - 1;
                vad = 1'b1;
            end else begin
                vad = 1'b0;
            end
        end else begin
            vad = speech;
        end
        m_fcnt = (m_fcnt + 1) % 65536;
    endtask

    task automatic run_frame(input logic signed [15:0] s1, input logic signed [15:0] s0, input int stall,
                             output logic acc_rdy, output int lat, output logic [1:0] cls,
                             output logic vad, output bit stable, output logic [15:0] fc,
                             output logic [1:0] fc2);
        logic [15:0] fc0;
        @(negedge clk);
        acc_rdy     = score_ready;
        score_valid = 1'b1;
        score1      = s1;
        score0      = s0;
        dec_ready   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        score_valid = 1'b0;
        lat = 1;
        while (!dec_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        cls    = dec_class;
        vad    = dec_vad;
        fc0    = frame_cnt;
        stable = (score_ready === 1'b0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (dec_valid !== 1'b1 || dec_class !== cls || dec_vad !== vad ||
                frame_cnt !== fc0 || score_ready !== 1'b0 || busy !== 1'b1)
                stable = 1'b0;
        end
        dec_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dec_ready = 1'b0;
        fc  = frame_cnt;
        fc2 = w_frame_cnt;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; score_valid = 1'b0; dec_ready = 1'b0;
        score0 = '0; score1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (score_ready !== 1'b0) begin n_fail++; $display("FAIL reset_score_ready got=%b exp=0", score_ready); end
        n_checks++;
        if ({dec_valid, busy, dec_class, dec_vad} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs got v=%b b=%b c=%b vad=%b exp=0", dec_valid, busy, dec_class, dec_vad);
        end
        n_checks++;
        if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (score_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_score_ready got=%b exp=1", score_ready); end
        m_hang = 0;
        m_fcnt = 0;
    endtask

    task automatic test_basic();
        logic [1:0] ecls, cls, fc2; logic evad, vad, rdy; int lat; bit st; logic [15:0] fc;
        model_frame(16'sd100, -16'sd5, ecls, evad);
        run_frame(16'sd100, -16'sd5, 0, rdy, lat, cls, vad, st, fc, fc2);
        n_checks++;
        if (rdy !== 1'b1) begin n_fail++; $display("FAIL basic_accept_ready got=%b exp=1", rdy); end
        n_checks++;
        if (lat != LAT) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
        n_checks++;
        if (cls !== 2'b10) begin n_fail++; $display("FAIL basic_class got=%b exp=10", cls); end
        n_checks++;
        if (vad !== evad) begin n_fail++; $display("FAIL basic_vad got=%b exp=%b", vad, evad); end
        n_checks++;
        if (fc !== 16'(m_fcnt)) begin n_fail++; $display("FAIL basic_frame_cnt got=%0d exp=%0d", fc, m_fcnt); end
    endtask

    task automatic test_tie();
        logic [1:0] ecls, cls, fc2; logic evad, vad, rdy; int lat; bit st; logic [15:0] fc;
        model_frame(-16'sd32768, -16'sd32768, ecls, evad);
        run_frame(-16'sd32768, -16'sd32768, 0, rdy, lat, cls, vad, st, fc, fc2);
        n_checks++;
        if (cls !== ecls) begin n_fail++; $display("FAIL tie_class got=%b exp=%b", cls, ecls); end
        n_checks++;
        if (vad !== evad) begin n_fail++; $display("FAIL tie_vad got=%b exp=%b", vad, evad); end
    endtask

    task automatic test_hangover();
        logic [1:0] ecls, cls, fc2; logic evad, vad, rdy; int lat; bit st; logic [15:0] fc;
        logic signed [15:0] s1, s0;
        for (int i = 0; i < 4; i++) begin
            s1 = (i == 0) ? 16'sd50 : -16'sd10;
            s0 = (i == 0) ? 16'sd10 : 16'sd20;
            model_frame(s1, s0, ecls, evad);
            run_frame(s1, s0, 0, rdy, lat, cls, vad, st, fc, fc2);
            n_checks++;
            if (cls !== ecls) begin n_fail++; $display("FAIL hang_class[%0d] got=%b exp=%b", i, cls, ecls); end
            n_checks++;
            if (vad !== evad) begin n_fail++; $display("FAIL hang_vad[%0d] got=%b exp=%b", i, vad, evad); end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] ecls, cls, fc2; logic evad, vad, rdy; int lat; bit st; logic [15:0] fc;
        model_frame(-16'sd7, 16'sd3, ecls, evad);
        run_frame(-16'sd7, 16'sd3, 5, rdy, lat, cls, vad, st, fc, fc2);
        n_checks++;
        if (st !== 1'b1) begin n_fail++; $display("FAIL bp_stable got=%b exp=1", st); end
        n_checks++;
        if (cls !== ecls || vad !== evad) begin
            n_fail++; $display("FAIL bp_outputs got c=%b v=%b exp c=%b v=%b", cls, vad, ecls, evad);
        end
        n_checks++;
        if (fc !== 16'(m_fcnt)) begin n_fail++; $display("FAIL bp_frame_cnt got=%0d exp=%0d", fc, m_fcnt); end
    endtask

    task automatic test_clear();
        logic [1:0] ecls, cls, fc2; logic evad, vad, rdy; int lat; bit st; logic [15:0] fc;
        model_frame(16'sd40, 16'sd1, ecls, evad);
        run_frame(16'sd40, 16'sd1, 0, rdy, lat, cls, vad, st, fc, fc2);
        @(negedge clk);
        score_valid = 1'b1; score1 = -16'sd100; score0 = 16'sd100;
        @(posedge clk);
        @(negedge clk);
        score_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL clear_pre_busy got=%b exp=1", busy); end
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        m_hang = 0;
        m_fcnt = 0;
        n_checks++;
        if ({dec_valid, busy, dec_class, dec_vad} !== 5'b0) begin
            n_fail++; $display("FAIL clear_outputs got v=%b b=%b c=%b vad=%b exp=0", dec_valid, busy, dec_class, dec_vad);
        end
        n_checks++;
        if (frame_cnt !== 16'd0 || score_ready !== 1'b1) begin
            n_fail++; $display("FAIL clear_cnt_ready got cnt=%0d rdy=%b exp cnt=0 rdy=1", frame_cnt, score_ready);
        end
        model_frame(-16'sd3, 16'sd3, ecls, evad);
        run_frame(-16'sd3, 16'sd3, 0, rdy, lat, cls, vad, st, fc, fc2);
        n_checks++;
        if (vad !== evad) begin n_fail++; $display("FAIL clear_next_vad got=%b exp=%b", vad, evad); end
        n_checks++;
        if (fc !== 16'(m_fcnt)) begin n_fail++; $display("FAIL clear_next_cnt got=%0d exp=%0d", fc, m_fcnt); end
        @(negedge clk);
        score_valid = 1'b1; clear = 1'b1; score1 = 16'sd9; score0 = 16'sd0;
        @(posedge clk);
        @(negedge clk);
        score_valid = 1'b0; clear = 1'b0;
        m_hang = 0;
        m_fcnt = 0;
        n_checks++;
        if (busy !== 1'b0 || dec_valid !== 1'b0 || frame_cnt !== 16'd0) begin
            n_fail++; $display("FAIL clear_accept_discard got b=%b v=%b cnt=%0d exp 0", busy, dec_valid, frame_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] ecls, cls, fc2; logic evad, vad, rdy; int lat; bit st; logic [15:0] fc;
        int exp_seq [5] = '{1, 2, 3, 0, 1};
        logic signed [15:0] s1, s0;
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        m_hang = 0;
        m_fcnt = 0;
        for (int i = 0; i < 5; i++) begin
            s1 = 16'($urandom);
            s0 = 16'($urandom);
            model_frame(s1, s0, ecls, evad);
            run_frame(s1, s0, 0, rdy, lat, cls, vad, st, fc, fc2);
            n_checks++;
            if (fc2 !== 2'(exp_seq[i])) begin
                n_fail++; $display("FAIL wrap_cnt[%0d] got=%0d exp=%0d", i, fc2, exp_seq[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] ecls, cls, fc2; logic evad, vad, rdy; int lat; bit st; logic [15:0] fc;
        logic signed [15:0] s1, s0;
        int t1, t0, stall;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s1 = 16'($urandom);
                s0 = 16'($urandom);
            end else begin
                t1 = $urandom_range(0, 6);
                t0 = $urandom_range(0, 8);
                s1 = 16'(t1 - 3);
                s0 = 16'(t0 - 3);
            end
            stall = $urandom_range(0, 3);
            model_frame(s1, s0, ecls, evad);
            run_frame(s1, s0, stall, rdy, lat, cls, vad, st, fc, fc2);
            n_checks++;
            if (rdy !== 1'b1 || lat != LAT || st !== 1'b1) begin
                n_fail++; $display("FAIL rand_timing[%0d] got rdy=%b lat=%0d stable=%b exp 1/%0d/1", i, rdy, lat, st, LAT);
            end
            n_checks++;
            if (cls !== ecls || vad !== evad) begin
                n_fail++; $display("FAIL rand_decision[%0d] s1=%0d s0=%0d got c=%b v=%b exp c=%b v=%b",
                                   i, s1, s0, cls, vad, ecls, evad);
            end
            n_checks++;
            if (fc !== 16'(m_fcnt) || fc2 !== 2'(m_fcnt % 4)) begin
                n_fail++; $display("FAIL rand_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, fc, fc2, m_fcnt, m_fcnt % 4);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_hangover();
        test_backpressure();
        test_clear();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vad_decision_ctrl.md
# vad_decision_ctrl

Sequencer for the classifier's final stage. Accepts one pair of signed class scores per audio frame from the last binarized fully connected layer. It orders the score compare, applies speech hangover smoothing, and hands a per-frame decision to the downstream frame logic over a valid/ready handshake. It replaces free-running enable-driven comparison with a frame-accurate, back-pressurable decision path.

## Interface
Parameters:
- SCORE_W, 16, width of each signed class score
- HANG_LEN, 8, hangover length in frames after the last raw speech frame (1..255)
- FCNT_W, 16, width of the frame counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- clear  in  1  synchronous soft clear (flush in-flight frame, hangover, counter)
- score_valid  in  1  score pair available
- score_ready  out  1  block can accept a score pair
- score0  in  SCORE_W  signed score, class 2 (non-speech)
- score1  in  SCORE_W  signed score, class 1 (speech)
- dec_valid  out  1  decision available
- dec_ready  in  1  downstream accepts decision
- dec_class  out  2  raw class: 2'b10 class 1, 2'b01 class 2, 2'b00 none
- dec_vad  out  1  smoothed speech flag
- frame_cnt  out  FCNT_W  completed-frame count
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, CMP, SMOOTH, OUT.
- **IDLE:**
  - score_ready=1.
  - On score_valid, score0/score1 are registered and the FSM goes to CMP.
- **CMP:**
  - Signed compare.
  - score1 >= score0 → dec_class=2'b10; otherwise 2'b01. A tie resolves to class 1.
  - Next state is SMOOTH (or OUT when the macro is off).
- **SMOOTH:**
  - Hangover update from the raw class.
  - Raw class 1: hang_cnt <= HANG_LEN, dec_vad <= 1.
  - Raw class 2 with hang_cnt > 0: hang_cnt decrements, dec_vad <= 1.
  - Raw class 2 with hang_cnt == 0: dec_vad <= 0.
  - hang_cnt never underflows. Next state is OUT.
- **OUT:**
  - dec_valid=1; dec_class and dec_vad are held stable.
  - On dec_ready: frame_cnt increments (wraps at 2^FCNT_W-1 → 0) and the FSM returns to IDLE.
- score_ready=0 in every state except IDLE. No pass-through of a new score in the same cycle as the OUT handshake.
- **clear:**
  - Forces IDLE and dec_valid=0.
  - Zeroes hang_cnt, frame_cnt, dec_class and dec_vad.
  - Has priority over every handshake in the same cycle; an accept and a clear in the same cycle discard the frame.
- **rst:** identical effect to clear and has priority over it.

## Timing
- Reset values: score_ready=0 in the reset cycle and 1 from the first post-reset cycle (IDLE); dec_valid=0, dec_class=2'b00, dec_vad=0, frame_cnt=0, busy=0, hang_cnt=0.
- Latency with the macro defined:
  - Accept at edge T.
  - CMP during T+1, SMOOTH during T+2.
  - dec_valid high from T+3.
- Latency with the macro undefined: dec_valid high from T+2.
- Throughput: one frame per 4 cycles (3 without the macro) when dec_ready is held high.
- dec_valid stays asserted until the handshake. Outputs must not change while dec_valid=1 and dec_ready=0.
- busy is combinational from the state register.

## Configuration
- Macro: VAD_HANGOVER_EN.
- **Defined:** the SMOOTH state and hang_cnt exist; dec_vad follows the hangover rule above.
- **Undefined:**
  - SMOOTH and hang_cnt are removed; HANG_LEN is ignored.
  - dec_vad is set in CMP to (dec_class == 2'b10).
  - Latency drops by one cycle.

## Structure
- Shared package vad_pkg holds:
  - class encodings CLS_NONE=2'b00, CLS_1=2'b10, CLS_2=2'b01;
  - the state enum {IDLE, CMP, SMOOTH, OUT}.
- One sub-module, vad_hangover: it owns hang_cnt and the smoothing rule, is instantiated only under VAD_HANGOVER_EN, and has ports clk, rst, clr, upd, raw_speech, vad.

## Test plan
- Reset, then score1=100, score0=-5, dec_ready=1 → dec_valid at T+3, dec_class=2'b10, dec_vad=1, frame_cnt=1.
- Tie: score1=score0=-32768 → dec_class=2'b10.
- Hangover (HANG_LEN=2): frames speech, non, non, non → dec_vad 1,1,1,0; dec_class 10,01,01,01.
- Back-pressure: dec_ready low 5 cycles in OUT → dec_valid held, outputs stable, score_ready=0, frame_cnt unchanged until the handshake.
- clear asserted in SMOOTH with hang_cnt=2 → next cycle IDLE, dec_valid=0, frame_cnt=0; next non-speech frame gives dec_vad=0.
- FCNT_W=2, five frames → frame_cnt sequence 1,2,3,0,1. Also repeat the first scenario without VAD_HANGOVER_EN → dec_valid at T+2.
